// File: rtl/fetch_queue_unit.sv
// Dual-issue fetch queue: issues 8-byte instruction-memory reads under a credit rule
// and buffers returned pairs for IF/ID. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = 32'h40200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [63:0] imemData,
  output logic [31:0] instruction1,
  output logic [31:0] instruction2,
  output logic [31:0] pc1,
  output logic        valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_LIM = DEPTH[CW:0];
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [PW-1:0] PTR_ONE   = 1;

  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [31:0] pc;
  } entry_t;

  entry_t        queueMem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [31:0]   fetchPC, reqAddr;
  logic          inflight, oddPending;
  logic          respLive, bypassHit, pushEn, popEn;
  entry_t        respEntry, headEntry;
  logic          unusedRedirectLsbs;

  assign unusedRedirectLsbs = ^redirectPC[1:0];

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    imemReq   = !reset && !redirect && (occupancy < DEPTH_LIM);
    imemAddr  = imemReq ? fetchPC : reqAddr;

    // A response is killed by a redirect in its data cycle.
    respLive         = inflight && !redirect;
    respEntry.instr1 = oddPending ? NOP_WORD : imemData[63:32];
    respEntry.instr2 = imemData[31:0];
    respEntry.pc     = reqAddr;
    headEntry        = queueMem[rdPtr];

`ifdef FETCH_QUEUE_BYPASS_EN
    bypassHit = respLive && (count == '0) && !stall;
`else
    bypassHit = 1'b0;
`endif
    pushEn = respLive && !bypassHit;
    popEn  = (count != '0) && !stall && !redirect;

    if (count != '0) begin
      valid        = 1'b1;
      instruction1 = headEntry.instr1;
      instruction2 = headEntry.instr2;
      pc1          = headEntry.pc;
    end else if (bypassHit) begin
      valid        = 1'b1;
      instruction1 = respEntry.instr1;
      instruction2 = respEntry.instr2;
      pc1          = respEntry.pc;
    end else begin
      valid        = 1'b0;
      instruction1 = NOP_WORD;
      instruction2 = NOP_WORD;
      pc1          = fetchPC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPC    <= '0;
      reqAddr    <= '0;
      count      <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      inflight   <= 1'b0;
      oddPending <= 1'b0;
    end else if (redirect) begin
      fetchPC    <= {redirectPC[31:3], 3'b000};
      count      <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      inflight   <= 1'b0;
      oddPending <= redirectPC[2];
    end else begin
      inflight <= imemReq;
      if (imemReq) begin
        fetchPC <= fetchPC + 32'd8;
        reqAddr <= fetchPC;
      end
      if (respLive) oddPending <= 1'b0;
      if (pushEn)   wrPtr <= wrPtr + PTR_ONE;
      if (popEn)    rdPtr <= rdPtr + PTR_ONE;
      if (pushEn && !popEn)      count <= count + CNT_ONE;
      else if (!pushEn && popEn) count <= count - CNT_ONE;
    end
  end

  // NOTE: queue storage has no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (pushEn) queueMem[wrPtr] <= respEntry;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: memory responder, scoreboard monitor and
// directed scenario tasks. Build with FETCH_QUEUE_BYPASS_EN to check the bypass variant.
module tb_fetch_queue_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h40200000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [63:0] imemData = '0;
  logic [31:0] instruction1, instruction2, pc1;
  logic        valid;

  int testsRun = 0;
  int testsFailed = 0;
  bit monEn = 1'b0;

  fetch_queue_unit #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemData(imemData),
    .instruction1(instruction1), .instruction2(instruction2), .pc1(pc1), .valid(valid)
  );

  always #5 clk = ~clk;

  // Memory returns {addr, addr+4} one cycle after each request.
  always @(posedge clk) imemData <= imemReq ? {imemAddr, imemAddr + 32'd4} : 64'hBAD0BAD0_BAD0BAD0;

  typedef struct {
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] pc;
  } pair_t;

  pair_t       expQ[$];
  pair_t       mEntry, monHead;
  bit          pendValid = 1'b0, oddPending = 1'b0, mHeadValid, mReq, monReq, monValid;
  logic [31:0] pendAddr = '0, mFetchPC = '0;

  // Reference model: expected pairs pushed as responses arrive, popped on consumption.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      expQ.delete();
      pendValid = 1'b0; pendAddr = '0; mFetchPC = '0; oddPending = 1'b0;
    end else if (redirect) begin
      expQ.delete();
      pendValid = 1'b0;
      mFetchPC = {redirectPC[31:3], 3'b000};
      oddPending = redirectPC[2];
    end else begin
      mHeadValid = expQ.size() > 0;
      mReq = (expQ.size() + int'(pendValid)) < DEPTH;
      if (mHeadValid && !stall) void'(expQ.pop_front());
      if (pendValid) begin
        mEntry = '{oddPending ? NOP : pendAddr, pendAddr + 32'd4, pendAddr};
        oddPending = 1'b0;
        if (!(BYP && !mHeadValid && !stall)) expQ.push_back(mEntry);
      end
      pendValid = mReq;
      if (mReq) begin
        pendAddr = mFetchPC;
        mFetchPC = mFetchPC + 32'd8;
      end
    end
  end

  // Scoreboard compare of every output on every cycle.
  always @(negedge clk) begin
    if (monEn && !reset) begin
      monReq = !redirect && ((expQ.size() + int'(pendValid)) < DEPTH);
      testsRun++;
      if (imemReq !== monReq) begin testsFailed++; $display("FAIL mon_imemReq t=%0t got %b exp %b", $time, imemReq, monReq); end
      if (monReq) begin
        testsRun++;
        if (imemAddr !== mFetchPC) begin testsFailed++; $display("FAIL mon_imemAddr t=%0t got %h exp %h", $time, imemAddr, mFetchPC); end
      end
      monValid = 1'b0;
      if (expQ.size() > 0) begin
        monValid = 1'b1; monHead = expQ[0];
      end else if (BYP && pendValid && !stall && !redirect) begin
        monValid = 1'b1; monHead = '{oddPending ? NOP : pendAddr, pendAddr + 32'd4, pendAddr};
      end else begin
        monHead = '{NOP, NOP, mFetchPC};
      end
      testsRun++;
      if (valid !== monValid) begin testsFailed++; $display("FAIL mon_valid t=%0t got %b exp %b", $time, valid, monValid); end
      testsRun++;
      if ({instruction1, instruction2, pc1} !== {monHead.i1, monHead.i2, monHead.pc}) begin
        testsFailed++;
        $display("FAIL mon_pair t=%0t got %h/%h/%h exp %h/%h/%h", $time, instruction1, instruction2, pc1, monHead.i1, monHead.i2, monHead.pc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit st);
    cyc();
    reset = 1'b1; stall = st; redirect = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  // Returns cycles until valid (0 = current cycle), 99 if it never rises; ends at that negedge.
  task automatic wait_valid(output int k);
    k = 99;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin k = i; break; end
      cyc();
    end
  endtask

  task automatic test_reset();
    cyc();
    @(negedge clk);
    testsRun++; if (imemReq !== 1'b0) begin testsFailed++; $display("FAIL reset_imemReq got %b exp 0", imemReq); end
    testsRun++; if (imemAddr !== 32'd0) begin testsFailed++; $display("FAIL reset_imemAddr got %h exp 0", imemAddr); end
    testsRun++; if (valid !== 1'b0) begin testsFailed++; $display("FAIL reset_valid got %b exp 0", valid); end
    testsRun++; if (instruction1 !== NOP || instruction2 !== NOP) begin testsFailed++; $display("FAIL reset_instr got %h/%h exp %h", instruction1, instruction2, NOP); end
    testsRun++; if (pc1 !== 32'd0) begin testsFailed++; $display("FAIL reset_pc1 got %h exp 0", pc1); end
    cyc();
    reset = 1'b0;
    monEn = 1'b1;
    @(negedge clk);
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin testsFailed++; $display("FAIL first_req got %b@%h exp 1@0", imemReq, imemAddr); end
  endtask

  task automatic test_stream();
    int k;
    do_reset(1'b0);
    wait_valid(k);
    testsRun++; if (k !== LAT) begin testsFailed++; $display("FAIL stream_latency got %0d exp %0d", k, LAT); end
    testsRun++; if (pc1 !== 32'd0 || instruction2 !== 32'd4) begin testsFailed++; $display("FAIL stream_first got %h/%h exp 0/4", pc1, instruction2); end
    for (int j = 1; j < 6; j++) begin
      cyc();
      @(negedge clk);
      testsRun++;
      if (valid !== 1'b1 || pc1 !== 32'(8 * j)) begin testsFailed++; $display("FAIL stream_pair%0d got %b/%h exp 1/%h", j, valid, pc1, 32'(8 * j)); end
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imemReq === 1'b1) nreq++;
      if (i < 9) cyc();
    end
    testsRun++; if (nreq != DEPTH) begin testsFailed++; $display("FAIL stall_reqs got %0d exp %0d", nreq, DEPTH); end
    testsRun++; if (imemReq !== 1'b0 || valid !== 1'b1 || pc1 !== 32'd0) begin testsFailed++; $display("FAIL stall_hold got %b/%b/%h exp 0/1/0", imemReq, valid, pc1); end
    cyc();
    stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      testsRun++;
      if (valid !== 1'b1 || pc1 !== 32'(8 * j)) begin testsFailed++; $display("FAIL stall_order%0d got %b/%h exp 1/%h", j, valid, pc1, 32'(8 * j)); end
      cyc();
    end
  endtask

  task automatic test_redirect();
    int k;
    do_reset(1'b0);
    repeat (5) cyc();
    redirect = 1'b1; redirectPC = 32'h100;
    @(negedge clk);
    testsRun++; if (imemReq !== 1'b0) begin testsFailed++; $display("FAIL redir_req got %b exp 0", imemReq); end
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin testsFailed++; $display("FAIL redir_addr got %b@%h exp 1@100", imemReq, imemAddr); end
    testsRun++; if (valid !== 1'b0) begin testsFailed++; $display("FAIL redir_flush got %b exp 0", valid); end
    cyc();
    wait_valid(k);
    testsRun++; if (k !== LAT - 1) begin testsFailed++; $display("FAIL redir_latency got %0d exp %0d", k, LAT - 1); end
    testsRun++; if (pc1 !== 32'h100 || instruction1 !== 32'h100) begin testsFailed++; $display("FAIL redir_first got %h/%h exp 100/100", pc1, instruction1); end
  endtask

  task automatic test_odd_redirect();
    int k;
    do_reset(1'b0);
    repeat (4) cyc();
    redirect = 1'b1; redirectPC = 32'h10C;
    cyc();
    redirect = 1'b0;
    wait_valid(k);
    testsRun++; if (k !== LAT) begin testsFailed++; $display("FAIL odd_latency got %0d exp %0d", k, LAT); end
    testsRun++;
    if (pc1 !== 32'h108 || instruction1 !== NOP || instruction2 !== 32'h10C) begin
      testsFailed++; $display("FAIL odd_first got %h/%h/%h exp 108/%h/10c", pc1, instruction1, instruction2, NOP);
    end
    cyc();
    @(negedge clk);
    testsRun++; if (pc1 !== 32'h110 || instruction1 !== 32'h110) begin testsFailed++; $display("FAIL odd_second got %h/%h exp 110/110", pc1, instruction1); end
    cyc();
    redirect = 1'b1; redirectPC = 32'h10C;
    cyc();
    redirectPC = 32'h200;
    cyc();
    redirect = 1'b0;
    wait_valid(k);
    testsRun++; if (k !== LAT) begin testsFailed++; $display("FAIL odd_override_latency got %0d exp %0d", k, LAT); end
    testsRun++; if (pc1 !== 32'h200 || instruction1 !== 32'h200) begin testsFailed++; $display("FAIL odd_override got %h/%h exp 200/200", pc1, instruction1); end
  endtask

  task automatic test_redirect_stall_full();
    int k;
    do_reset(1'b1);
    repeat (8) cyc();
    @(negedge clk);
    testsRun++; if (imemReq !== 1'b0 || valid !== 1'b1) begin testsFailed++; $display("FAIL full_state got %b/%b exp 0/1", imemReq, valid); end
    cyc();
    redirect = 1'b1; redirectPC = 32'h200;
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    testsRun++; if (valid !== 1'b0) begin testsFailed++; $display("FAIL full_flush got %b exp 0", valid); end
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 32'h200) begin testsFailed++; $display("FAIL full_restart got %b@%h exp 1@200", imemReq, imemAddr); end
    cyc();
    wait_valid(k);
    testsRun++; if (k !== 1 || pc1 !== 32'h200) begin testsFailed++; $display("FAIL full_first got %0d/%h exp 1/200", k, pc1); end
    cyc();
    stall = 1'b0;
    @(negedge clk);
    testsRun++; if (pc1 !== 32'h200) begin testsFailed++; $display("FAIL full_hold got %h exp 200", pc1); end
    cyc();
    @(negedge clk);
    testsRun++; if (pc1 !== 32'h208) begin testsFailed++; $display("FAIL full_next got %h exp 208", pc1); end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset(1'b0);
    repeat (4) cyc();
    #1 reset = 1'b1;
    #1;
    testsRun++; if (valid !== 1'b0 || imemReq !== 1'b0) begin testsFailed++; $display("FAIL mid_async got %b/%b exp 0/0", valid, imemReq); end
    #1 reset = 1'b0;
    @(negedge clk);
    testsRun++; if (valid !== 1'b0 || pc1 !== 32'd0) begin testsFailed++; $display("FAIL mid_cleared got %b/%h exp 0/0", valid, pc1); end
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin testsFailed++; $display("FAIL mid_req got %b@%h exp 1@0", imemReq, imemAddr); end
    cyc();
    wait_valid(k);
    testsRun++; if (k !== LAT - 1) begin testsFailed++; $display("FAIL mid_latency got %0d exp %0d", k, LAT - 1); end
    testsRun++; if (pc1 !== 32'd0 || instruction2 !== 32'd4) begin testsFailed++; $display("FAIL mid_first got %h/%h exp 0/4", pc1, instruction2); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_odd_redirect();
    test_redirect_stall_full();
    test_reset_mid();
    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter DEPTH, default 4: number of instruction-pair entries in the queue, a power of two, at least 2.
REQ-002 Parameter NOP_WORD, default 32'h40200000: the even-pipe no-op instruction word.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous and active-high.
REQ-005 Port stall, input, 1: downstream IF/ID stall; holds the head entry.
REQ-006 Port redirect, input, 1: branch-mispredict flush and PC redirect.
REQ-007 Port redirectPC, input, 32: byte address of the redirect target.
REQ-008 Port imemReq, output, 1: instruction-memory read request.
REQ-009 Port imemAddr, output, 32: byte address of the request, 8-byte aligned.
REQ-010 Port imemData, input, 64: read data, valid exactly 1 cycle after imemReq; [63:32] is the lower-address word.
REQ-011 Port instruction1, output, 32: even-slot instruction to IF/ID.
REQ-012 Port instruction2, output, 32: odd-slot instruction to IF/ID.
REQ-013 Port pc1, output, 32: byte address of instruction1.
REQ-014 Port valid, output, 1: the head entry is presented.

Function
REQ-015 The fetch PC (fetchPC) shall advance by 8 on each cycle that imemReq=1.
REQ-016 imemReq shall be 1 when count+inflight<DEPTH and redirect=0; count is the number of occupied entries and inflight is a 1-bit outstanding-request flag.
REQ-017 When imemReq=1, imemAddr shall equal fetchPC; otherwise imemAddr shall hold its last value.
REQ-018 A response that is not killed shall be pushed at the rising edge ending its data cycle, with the entry {imemData[63:32], imemData[31:0], request address}.
REQ-019 When count>0: valid=1 and instruction1/instruction2/pc1 shall come from the head entry. When count=0: valid=0, both instructions=NOP_WORD and pc1=fetchPC.
REQ-020 The head entry shall pop on a rising edge where valid=1 and stall=0; push and pop in the same cycle shall leave count unchanged.
REQ-021 Overflow shall be impossible by construction (credit rule REQ-016); underflow shall be impossible because pop requires valid.
REQ-022 Read and write pointers shall be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-023 Redirect shall have priority over stall and push, and at the next edge shall:
- clear count and both pointers;
- kill any inflight response;
- set fetchPC={redirectPC[31:3],3'b000}.
REQ-024 When redirectPC[2]=1, the first pair pushed after the redirect shall have instruction1 replaced by NOP_WORD (pc1 still 8-aligned). A later redirect before that push shall override this replacement rule.
REQ-025 Minimum latency shall be 2 cycles, from imemReq to valid=1 for that pair.

Reset
REQ-026 Reset shall asynchronously set:
- fetchPC=0, count=0, pointers=0, inflight=0, odd-target flag=0;
- imemReq=0, imemAddr=0, valid=0, instruction1=instruction2=NOP_WORD, pc1=0.
REQ-027 Reset asserted mid-operation shall discard all queue and inflight state; a response arriving after reset release shall not be pushed.
REQ-028 The first imemReq (address 0) shall occur in the first cycle after reset deasserts.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN, when defined: if count=0, a non-killed response is arriving and stall=0, that response shall drive the outputs with valid=1 in the same cycle and shall not be pushed. The odd-target NOP rule shall still apply. Minimum latency becomes 1 cycle.
REQ-030 When FETCH_QUEUE_BYPASS_EN is undefined, every response shall pass through the queue.

Verification
REQ-031 Reset release with stall=0 and memory returning {addr,addr+4} -> imemAddr 0,8,16,...; valid rises on cycle 2 with pc1=0, instruction2=4; one pair per cycle thereafter.
REQ-032 stall held high for 10 cycles -> imemReq stops once count+inflight=4; outputs held at pc1=0; after release, pairs 0,8,16,24 are presented in order.
REQ-033 redirect with redirectPC=0x100 while a response is inflight -> stale pair never presented; next imemAddr=0x100; valid=0 for 2 cycles.
REQ-034 redirectPC=0x10C -> first presented pair pc1=0x108, instruction1=NOP_WORD, instruction2=word at 0x10C.
REQ-035 redirect and stall high in the same cycle while full -> queue empties and fetch restarts at the target.
REQ-036 With FETCH_QUEUE_BYPASS_EN defined, after reset -> valid=1 on cycle 1; with the macro undefined -> valid=1 on cycle 2.
